// File: rtl/rx_chan_sched.sv
// rtl/rx_chan_sched.sv - receive channel scheduler: packs enabled 16-bit samples into 32-bit FIFO words
// Owns the serial config registers and the overrun/packet-ready status.
module rx_chan_sched #(
    parameter logic [6:0] ADDR_CTRL   = 7'd32,
    parameter logic [6:0] ADDR_THRESH = 7'd33,
    parameter int         FIFO_DEPTH  = 4096
) (
    input  logic        rx_clk,
    input  logic        reset,
    input  logic [6:0]  serial_addr,
    input  logic [31:0] serial_data,
    input  logic        serial_strobe,
    input  logic [15:0] ch_0,
    input  logic [15:0] ch_1,
    input  logic [15:0] ch_2,
    input  logic [15:0] ch_3,
    input  logic        rxstrobe,
    input  logic [12:0] fifo_level,
    input  logic        fifo_full,
    input  logic        clear_status,
    output logic [31:0] fifo_data,
    output logic        fifo_wrreq,
    output logic        have_pkt_rdy,
    output logic        rx_overrun,
    output logic [15:0] drop_count,
    output logic        busy
);

    typedef enum logic {S_IDLE = 1'b0, S_PACK = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [3:0]  mask_q;
    logic        run_q;
    logic [12:0] thresh_q;
    logic [31:0] data_q;
    logic [31:0] word1_q;
    logic        pend_q;
    logic        have_q;
    logic        ovr_q;
    logic [15:0] drops_q;

    logic [15:0] ch [4];
    logic [15:0] slot [4];
    logic [2:0]  n_en;
    logic        two_words;
    logic [13:0] level_sum;
    logic        no_room;
    logic        strobe_valid;
    logic        accept;
    logic        drop;
    logic        unused_bits;

    assign ch[0] = ch_0;
    assign ch[1] = ch_1;
    assign ch[2] = ch_2;
    assign ch[3] = ch_3;
    assign unused_bits = ^serial_data[31:13];

    // Compact the enabled channels into consecutive slots, ascending index order.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            slot[i] = '0;
        end
        n_en = '0;
        for (int i = 0; i < 4; i++) begin
            if (mask_q[i]) begin
                slot[n_en[1:0]] = ch[i];
                n_en = n_en + 3'd1;
            end
        end
    end

    assign two_words    = (n_en >= 3'd3);
    assign level_sum    = {1'b0, fifo_level} + (two_words ? 14'd2 : 14'd1);
    assign no_room      = fifo_full || ({18'd0, level_sum} > $unsigned(FIFO_DEPTH));
    assign strobe_valid = rxstrobe && run_q && (mask_q != 4'd0);
    assign accept       = (state_q == S_IDLE) && strobe_valid && !no_room;
    assign drop         = strobe_valid && ((state_q == S_PACK) || no_room);

    always_ff @(posedge rx_clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_PACK;
            S_PACK:  if (!pend_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_wrreq = (state_q == S_PACK);
        busy       = (state_q == S_PACK);
    end

    always_ff @(posedge rx_clk or negedge reset) begin
        if (!reset) begin
            mask_q   <= 4'd0;
            run_q    <= 1'b0;
            thresh_q <= 13'd1024;
        end else if (serial_strobe) begin
            if (serial_addr == ADDR_CTRL) begin
                mask_q <= serial_data[3:0];
                run_q  <= serial_data[4];
            end else if (serial_addr == ADDR_THRESH) begin
                thresh_q <= serial_data[12:0];
            end
        end
    end

    // The whole set is packed at acceptance so config writes during PACK cannot disturb it.
    always_ff @(posedge rx_clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            word1_q <= '0;
            pend_q  <= 1'b0;
        end else if (accept) begin
            data_q  <= {slot[1], slot[0]};
            word1_q <= {slot[3], slot[2]};
            pend_q  <= two_words;
        end else if (state_q == S_PACK && pend_q) begin
            data_q <= word1_q;
            pend_q <= 1'b0;
        end
    end

    always_ff @(posedge rx_clk or negedge reset) begin
        if (!reset) begin
            have_q  <= 1'b0;
            ovr_q   <= 1'b0;
            drops_q <= '0;
        end else begin
            have_q <= (fifo_level >= thresh_q);
            if (drop) begin
                ovr_q   <= 1'b1;
                drops_q <= clear_status ? 16'd1 :
                           (drops_q == 16'hFFFF) ? drops_q : drops_q + 16'd1;
            end else if (clear_status) begin
                ovr_q   <= 1'b0;
                drops_q <= '0;
            end
        end
    end

    assign fifo_data    = data_q;
    assign have_pkt_rdy = have_q;
    assign rx_overrun   = ovr_q;
    assign drop_count   = drops_q;

endmodule

// File: doc/rx_chan_sched.md
# rx_chan_sched

Single-clock scheduler that sits between the four 16-bit receive channel outputs and the write port of the receive FIFO. On each accepted `rxstrobe` it snapshots the enabled channels and emits them as packed 32-bit FIFO words, one word per cycle. Each sample set is written to the FIFO entirely or dropped entirely, decided by FIFO headroom at acceptance. It also owns the serial-bus configuration registers, which hold the channel mask, the run enable and the packet-ready threshold, and it generates the `have_pkt_rdy` and `rx_overrun` status outputs.

## Interface
- `ADDR_CTRL`, default 7'd32: serial address of the control register.
  - [3:0] channel enable mask.
  - [4] run.
- `ADDR_THRESH`, default 7'd33: serial address of the threshold register.
  - [12:0] packet-ready threshold in words.
- `FIFO_DEPTH`, default 4096: FIFO capacity in 32-bit words.

Ports:
- `rx_clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `serial_addr`  in  7  configuration register address.
- `serial_data`  in  32  configuration write data.
- `serial_strobe`  in  1  one-cycle write qualifier.
- `ch_0`, `ch_1`, `ch_2`, `ch_3`  in  16 each  channel samples; valid in the `rxstrobe` cycle.
- `rxstrobe`  in  1  one-cycle sample-valid pulse.
- `fifo_level`  in  13  FIFO write-side used-word count.
- `fifo_full`  in  1  FIFO write-side full flag.
- `clear_status`  in  1  one-cycle clear of the sticky status outputs.
- `fifo_data`  out  32  packed word.
- `fifo_wrreq`  out  1  write strobe; qualifies `fifo_data` in the same cycle.
- `have_pkt_rdy`  out  1  FIFO level is at or above the threshold.
- `rx_overrun`  out  1  sticky flag: a sample set was dropped.
- `drop_count`  out  16  count of dropped sets; saturates at 16'hFFFF.
- `busy`  out  1  FSM is in state PACK.

## Operation
- **Register reset values:**
  - mask = 4'b0000.
  - run = 0.
  - threshold = 13'd1024.
- **Register writes:** a write occurs when `serial_strobe`=1 and `serial_addr` matches. It takes effect on the next cycle. Other addresses are ignored.
- **State IDLE:**
  - A set is accepted when `rxstrobe`=1, run=1 and mask≠0.
  - On acceptance, latch `ch_0`..`ch_3` and the current mask.
  - words = ceil(popcount(mask)/2), which is 1 or 2.
  - If `fifo_full`=1 or `fifo_level` + words > `FIFO_DEPTH`, the set is dropped:
    - set `rx_overrun`;
    - increment `drop_count`, saturating;
    - stay in IDLE.
  - Otherwise go to PACK.
  - `rxstrobe` with run=0 or mask=0 is ignored silently, with no overrun.
- **State PACK:**
  - Enabled channels are taken in ascending index order and paired as {second, first}: the first sample goes to [15:0], the second to [31:16].
  - With an odd channel count, the final word has [31:16] = 16'h0000.
  - One word is written per cycle.
  - After the last word, return to IDLE.
  - Headroom was checked at acceptance, so `fifo_full` is not re-sampled during PACK.
- **`rxstrobe` during PACK:** the set is dropped; set `rx_overrun` and increment `drop_count`. The in-progress set completes unaffected.
- **Configuration changes during PACK:** a mask or run write does not affect the in-progress set, which uses the latched mask. Clearing run never truncates a set.
- **`have_pkt_rdy`:** registered, = (`fifo_level` ≥ threshold), updated every cycle.
- **`clear_status`:** clears `rx_overrun` and `drop_count`. If a drop occurs in the same cycle, the drop wins: `rx_overrun`=1 and `drop_count`=1.

## Timing
- **Reset values of all outputs (asynchronous):**
  - `fifo_data` = 0.
  - `fifo_wrreq` = 0.
  - `have_pkt_rdy` = 0.
  - `rx_overrun` = 0.
  - `drop_count` = 0.
  - `busy` = 0.
  - FSM returns to IDLE and the configuration registers return to their reset values.
- **Write latency:** for `rxstrobe` in cycle t, the word writes occur as follows:
  - first word: `fifo_wrreq` in cycle t+1;
  - second word, if any: `fifo_wrreq` in cycle t+2.
- `busy` is high during exactly the `fifo_wrreq` cycles of an accepted set.
- Minimum `rxstrobe` spacing without drops:
  - 2 cycles for 1–2 enabled channels;
  - 3 cycles for 3–4 enabled channels.
- `rx_overrun` and `drop_count` update in cycle t+1 after the offending strobe.
- `have_pkt_rdy` lags `fifo_level` by 1 cycle.
- **Reset mid-PACK:** the set is abandoned. No further `fifo_wrreq` is issued.

## Test plan
- **Four channels enabled:** configure mask=4'hF, run=1; `ch_0..3` = 1111/2222/3333/4444 (hex); `rxstrobe` at t → `fifo_data` 2222_1111 at t+1, then 4444_3333 at t+2. `busy` is high for exactly those 2 cycles.
- **Odd mask:** mask=4'b1011, samples A/B/-/D → words B_A, then 0000_D. With mask=4'b0100 → a single word 0000_C.
- **Headroom drop:** `fifo_level`=4095 with 4 channels enabled → no `fifo_wrreq`, `rx_overrun`=1, `drop_count`=1. With `fifo_level`=4094 → both words are written.
- **Back-to-back strobes:** 4 channels enabled, strobes at t and t+1 → the t set completes, the t+1 set is dropped and `drop_count`=1. Strobes at t and t+3 are both written.
- **Status and config:** `clear_status` coincident with a drop → `rx_overrun`=1, `drop_count`=1. Run cleared at t+1 of a 2-word set → the second word is still written. Threshold=8 with `fifo_level` going 7→8 → `have_pkt_rdy` rises 1 cycle later.
- **Reset:** assert `reset` low asynchronously during PACK → all outputs are 0 immediately. After release, mask=0 and run=0.
